// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with writeback scoreboard
// Two writeback requesters share one write port; a reservation scoreboard drives decode hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [ADDR_W-1:0]      rd_addrA,
  input  logic [ADDR_W-1:0]      rd_addrB,
  output logic                   hazard_A,
  output logic                   hazard_B,
  output logic [2**ADDR_W-1:0]   busy_map,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data
);

  localparam int NREG = 2**ADDR_W;

  logic            last_grant;
  logic            grant0;
  logic            grant1;
  logic [NREG-1:0] busy_next;

  // Grants are gated by reset so nothing is accepted while nrst is low.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (nrst) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN) begin
          grant0 = last_grant;
          grant1 = ~last_grant;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Writes to r0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (grant0) begin
      wr_en   <= (req0_addr != '0);
      wr_addr <= req0_addr;
      wr_data <= req0_data;
    end else if (grant1) begin
      wr_en   <= (req1_addr != '0);
      wr_addr <= req1_addr;
      wr_data <= req1_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Clear first, then set, so a same-edge reservation survives the retiring write.
  always_comb begin
    busy_next = busy_map;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_map <= '0;
    end else begin
      busy_map <= busy_next;
    end
  end

  // The in-flight write term covers the cycle before the register file holds the data.
  assign hazard_A = (rd_addrA != '0) &&
                    (busy_map[rd_addrA] || (wr_en && (wr_addr == rd_addrA)));
  assign hazard_B = (rd_addrB != '0) &&
                    (busy_map[rd_addrB] || (wr_en && (wr_addr == rd_addrB)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench for regfile_wb_arbiter (round-robin and fixed priority)
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        vld  [2][2];
  logic [4:0]  adr  [2][2];
  logic [31:0] dat  [2][2];
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  rd_a;
  logic [4:0]  rd_b;

  logic        rdy0  [2];
  logic        rdy1  [2];
  logic        haz_a [2];
  logic        haz_b [2];
  logic [31:0] busy  [2];
  logic        wen   [2];
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(gi == 0)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .req0_valid (vld[gi][0]),
      .req0_addr  (adr[gi][0]),
      .req0_data  (dat[gi][0]),
      .req0_ready (rdy0[gi]),
      .req1_valid (vld[gi][1]),
      .req1_addr  (adr[gi][1]),
      .req1_data  (dat[gi][1]),
      .req1_ready (rdy1[gi]),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .rd_addrA   (rd_a),
      .rd_addrB   (rd_b),
      .hazard_A   (haz_a[gi]),
      .hazard_B   (haz_b[gi]),
      .busy_map   (busy[gi]),
      .wr_en      (wen[gi]),
      .wr_addr    (waddr[gi]),
      .wr_data    (wdata[gi])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who won last, what is in flight, which registers are reserved.
  bit          m_known;
  int          m_last   [2];
  bit          m_wen    [2];
  bit [4:0]    m_waddr  [2];
  bit [31:0]   m_wdata  [2];
  bit          m_rsv    [2][32];
  bit          lost     [2][2];

  function automatic int winner(int i);
    if (!nrst) return -1;
    if (vld[i][0] && vld[i][1]) begin
      if (i == 0) return (m_last[i] == 0) ? 1 : 0;
      return 0;
    end
    if (vld[i][0]) return 0;
    if (vld[i][1]) return 1;
    return -1;
  endfunction

  function automatic bit model_hazard(int i, bit [4:0] ra);
    if (ra == 0) return 1'b0;
    return m_rsv[i][ra] || (m_wen[i] && m_waddr[i] == ra);
  endfunction

  function automatic bit [31:0] model_busy(int i);
    bit [31:0] v = '0;
    for (int k = 0; k < 32; k++) v[k] = m_rsv[i][k];
    return v;
  endfunction

  task automatic step();
    int g [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      g[i] = winner(i);
      check($sformatf("rdy0[%0d]", i), {31'b0, rdy0[i]}, {31'b0, g[i] == 0});
      check($sformatf("rdy1[%0d]", i), {31'b0, rdy1[i]}, {31'b0, g[i] == 1});
      if (m_known) begin
        check($sformatf("haz_a[%0d]", i), {31'b0, haz_a[i]}, {31'b0, model_hazard(i, rd_a)});
        check($sformatf("haz_b[%0d]", i), {31'b0, haz_b[i]}, {31'b0, model_hazard(i, rd_b)});
      end
      for (int r = 0; r < 2; r++) lost[i][r] = vld[i][r] && (g[i] != r);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!nrst) begin
        m_last[i]  = 1;
        m_wen[i]   = 1'b0;
        m_waddr[i] = '0;
        m_wdata[i] = '0;
        for (int k = 0; k < 32; k++) m_rsv[i][k] = 1'b0;
      end else begin
        // Retiring write frees its register; a reservation this same edge wins.
        if (m_wen[i]) m_rsv[i][m_waddr[i]] = 1'b0;
        if (rsv_en && rsv_addr != 0) m_rsv[i][rsv_addr] = 1'b1;
        if (g[i] >= 0) begin
          m_last[i]  = g[i];
          m_waddr[i] = adr[i][g[i]];
          m_wdata[i] = dat[i][g[i]];
          m_wen[i]   = (adr[i][g[i]] != 0);
        end else begin
          m_wen[i] = 1'b0;
        end
      end
    end
    if (!nrst) m_known = 1'b1;
    #1;
    if (m_known) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("wen[%0d]", i),   {31'b0, wen[i]}, {31'b0, m_wen[i]});
        check($sformatf("waddr[%0d]", i), {27'b0, waddr[i]}, {27'b0, m_waddr[i]});
        check($sformatf("wdata[%0d]", i), wdata[i], m_wdata[i]);
        check($sformatf("busy[%0d]", i),  busy[i], model_busy(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v, input logic [4:0] a, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      vld[i][r] = v;
      adr[i][r] = a;
      dat[i][r] = d;
    end
  endtask

  initial begin
    int rr_exp [4];
    rr_exp = '{3, 4, 3, 4};
    nrst = 1'b0; rsv_en = 1'b0; rsv_addr = '0; rd_a = '0; rd_b = '0;
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);

    // Reset held with a pending request, then first accept
    set_req(0, 1'b1, 5'd5, 32'hA5A5A5A5);
    step();
    step();
    check("rst_wen", {31'b0, wen[0]}, 32'd0);
    check("rst_busy", busy[0], 32'd0);
    nrst = 1'b1;
    step();
    check("first_wen", {31'b0, wen[0]}, 32'd1);
    check("first_waddr", {27'b0, waddr[0]}, 32'd5);
    check("first_wdata", wdata[0], 32'hA5A5A5A5);

    // Leave round-robin with req1 as last winner, then contend
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd4, 32'h44);
    step();
    set_req(0, 1'b1, 5'd3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr_waddr%0d", k), {27'b0, waddr[0]}, rr_exp[k]);
      check($sformatf("fp_waddr%0d", k), {27'b0, waddr[1]}, 32'd3);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    step();
    check("fp_req1_after_drop", {27'b0, waddr[1]}, 32'd4);
    set_req(1, 1'b0, 5'd0, 32'h0);

    // Reservation, writeback and hazard release
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_a = 5'd9;
    step();
    rsv_en = 1'b0;
    check("rsv9_busy", {31'b0, busy[0][9]}, 32'd1);
    set_req(1, 1'b1, 5'd9, 32'h99);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("haz9_inflight", {31'b0, haz_a[0]}, 32'd1);
    step();
    #1;
    check("haz9_clear", {31'b0, haz_a[0]}, 32'd0);
    check("busy9_clear", {31'b0, busy[0][9]}, 32'd0);

    // Same-edge set and clear
    set_req(1, 1'b1, 5'd7, 32'h77);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_en = 1'b0;
    check("same_edge_busy7", {31'b0, busy[0][7]}, 32'd1);

    // r0 handling
    set_req(0, 1'b1, 5'd0, 32'hDEAD);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("r0_wen", {31'b0, wen[0]}, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_a = 5'd0;
    step();
    rsv_en = 1'b0;
    check("r0_busy", {31'b0, busy[0][0]}, 32'd0);
    #1;
    check("r0_haz", {31'b0, haz_a[0]}, 32'd0);

    // Randomized traffic; losers hold their request, occasional mid-run reset
    for (int n = 0; n < 600; n++) begin
      nrst     = ($urandom_range(0, 49) != 0);
      rsv_en   = $urandom_range(0, 3) == 0;
      rsv_addr = 5'($urandom_range(0, 7));
      rd_a     = 5'($urandom_range(0, 7));
      rd_b     = 5'($urandom_range(0, 7));
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (!lost[i][r]) begin
            vld[i][r] = $urandom_range(0, 2) != 0;
            adr[i][r] = 5'($urandom_range(0, 7));
            dat[i][r] = $urandom;
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
